// File: rtl/wb_pkg.sv
`default_nettype none
// ==========================================================================
// wb_pkg -- shared widths and buffer entry type for wb_arbiter.  Rev 1.0
// ==========================================================================
package wb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;

  typedef struct packed {
    logic                valid;
    logic [REG_AW-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ==========================================================================
// wb_arbiter_if -- fast/slow write ports, RF write port, decode lookups. Rev 1.0
// ==========================================================================
interface wb_arbiter_if import wb_pkg::*; #(
  parameter int XLEN = XLEN_DEF
);

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              WE3;
  logic [REG_AW-1:0] AD3;
  logic [XLEN-1:0]   WD3;
  logic [REG_AW-1:0] AD1;
  logic [REG_AW-1:0] AD2;
  logic              rs1_pending;
  logic              rs2_pending;
  logic [XLEN-1:0]   rs1_fwd_data;
  logic [XLEN-1:0]   rs2_fwd_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output WE3, AD3, WD3,
    input  AD1, AD2,
    output rs1_pending, rs2_pending, rs1_fwd_data, rs2_fwd_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  WE3, AD3, WD3,
    output AD1, AD2,
    input  rs1_pending, rs2_pending, rs1_fwd_data, rs2_fwd_data
  );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ==========================================================================
// wb_fifo -- slow-port circular buffer with squash and rd match vectors.
// Forward-data select built only with WB_ARBITER_FWD_EN.  Rev 1.0
// ==========================================================================
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_push,
  input  wire logic [REG_AW-1:0]          i_push_rd,
  input  wire logic [XLEN-1:0]            i_push_data,
  input  wire logic                       i_pop,
  input  wire logic                       i_squash,
  input  wire logic [REG_AW-1:0]          i_squash_rd,
  input  wire logic [REG_AW-1:0]          i_ad1,
  input  wire logic [REG_AW-1:0]          i_ad2,
  output logic                            o_head_valid,
  output logic [REG_AW-1:0]               o_head_rd,
  output logic [XLEN-1:0]                 o_head_data,
  output logic [$clog2(DEPTH+1)-1:0]      o_count,
  output logic [DEPTH-1:0]                o_match1,
  output logic [DEPTH-1:0]                o_match2
`ifdef WB_ARBITER_FWD_EN
  ,
  output logic [XLEN-1:0]                 o_fwd1_data,
  output logic [XLEN-1:0]                 o_fwd2_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  r_valid;
  logic [REG_AW-1:0] r_rd   [DEPTH];
  logic [XLEN-1:0]   r_data [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DEPTH-1:0]  w_squash_hit;
  logic              w_push_kill;

  always_comb begin
    w_squash_hit = '0;
    o_match1     = '0;
    o_match2     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_squash_hit[i] = i_squash && r_valid[i] && (r_rd[i] == i_squash_rd);
      o_match1[i]     = r_valid[i] && (r_rd[i] == i_ad1);
      o_match2[i]     = r_valid[i] && (r_rd[i] == i_ad2);
    end
  end

  // An entry arriving alongside a same-rd fast write is already stale.
  assign w_push_kill = i_squash && (i_squash_rd == i_push_rd);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_valid <= r_valid & ~w_squash_hit;
      if (i_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      if (i_push) begin
        r_valid[r_wptr] <= !w_push_kill;
        r_rd[r_wptr]    <= i_push_rd;
        r_data[r_wptr]  <= i_push_data;
        r_wptr          <= r_wptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_valid = r_valid[r_rptr];
  assign o_head_rd    = r_rd[r_rptr];
  assign o_head_data  = r_data[r_rptr];
  assign o_count      = r_count;

`ifdef WB_ARBITER_FWD_EN
  // Scan oldest to youngest so the youngest match is the last one assigned.
  always_comb begin
    o_fwd1_data = '0;
    o_fwd2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (o_match1[r_rptr + PW'(k)]) o_fwd1_data = r_data[r_rptr + PW'(k)];
      if (o_match2[r_rptr + PW'(k)]) o_fwd2_data = r_data[r_rptr + PW'(k)];
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ==========================================================================
// wb_arbiter -- register-file write-back arbiter, fast port wins, slow port
// buffered.  Optional forwarding: WB_ARBITER_FWD_EN.  Rev 1.0
// ==========================================================================
module wb_arbiter import wb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF
) (
  input  wire logic   clk,
  input  wire logic   rst,
  wb_arbiter_if.slave bus
);

  localparam int            CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic              w_fast_wr;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_head_valid;
  logic [REG_AW-1:0] w_head_rd;
  logic [XLEN-1:0]   w_head_data;
  logic [CW-1:0]     w_count;
  logic [DEPTH-1:0]  w_match1;
  logic [DEPTH-1:0]  w_match2;
  logic              w_wb_hit1;
  logic              w_wb_hit2;

  logic              r_we3;
  logic [REG_AW-1:0] r_ad3;
  logic [XLEN-1:0]   r_wd3;

  assign w_fast_wr = bus.alu_valid && (bus.alu_rd != '0);
  assign w_ready   = rst && (w_count != FULL_COUNT);
  // rd == 0 handshakes complete but never reach the buffer.
  assign w_push    = bus.lsu_valid && w_ready && (bus.lsu_rd != '0);
  assign w_pop     = !w_fast_wr && (w_count != '0);

`ifdef WB_ARBITER_FWD_EN
  logic [XLEN-1:0] w_fifo_fwd1;
  logic [XLEN-1:0] w_fifo_fwd2;
`endif

  wb_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_rd    (bus.lsu_rd),
    .i_push_data  (bus.lsu_data),
    .i_pop        (w_pop),
    .i_squash     (w_fast_wr),
    .i_squash_rd  (bus.alu_rd),
    .i_ad1        (bus.AD1),
    .i_ad2        (bus.AD2),
    .o_head_valid (w_head_valid),
    .o_head_rd    (w_head_rd),
    .o_head_data  (w_head_data),
    .o_count      (w_count),
    .o_match1     (w_match1),
    .o_match2     (w_match2)
`ifdef WB_ARBITER_FWD_EN
    ,
    .o_fwd1_data  (w_fifo_fwd1),
    .o_fwd2_data  (w_fifo_fwd2)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we3 <= 1'b0;
      r_ad3 <= '0;
      r_wd3 <= '0;
    end else if (w_fast_wr) begin
      r_we3 <= 1'b1;
      r_ad3 <= bus.alu_rd;
      r_wd3 <= bus.alu_data;
    end else if (w_pop && w_head_valid) begin
      r_we3 <= 1'b1;
      r_ad3 <= w_head_rd;
      r_wd3 <= w_head_data;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign bus.WE3       = r_we3;
  assign bus.AD3       = r_ad3;
  assign bus.WD3       = r_wd3;
  assign bus.lsu_ready = w_ready;

  assign w_wb_hit1 = r_we3 && (r_ad3 == bus.AD1);
  assign w_wb_hit2 = r_we3 && (r_ad3 == bus.AD2);

  assign bus.rs1_pending = rst && (bus.AD1 != '0) && ((|w_match1) || w_wb_hit1);
  assign bus.rs2_pending = rst && (bus.AD2 != '0) && ((|w_match2) || w_wb_hit2);

`ifdef WB_ARBITER_FWD_EN
  // The write-back stage is newer than anything still buffered.
  assign bus.rs1_fwd_data = w_wb_hit1 ? r_wd3 : w_fifo_fwd1;
  assign bus.rs2_fwd_data = w_wb_hit2 ? r_wd3 : w_fifo_fwd2;
`else
  assign bus.rs1_fwd_data = '0;
  assign bus.rs2_fwd_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_wb_arbiter -- directed and random checks against a queue model.  Rev 1.0
// ==========================================================================
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = XLEN_DEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_arbiter_if #(.XLEN(XLEN)) bus ();

  wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the buffer is a plain queue, the RF write stage three vars.
  wb_entry_t         m_q[$];
  logic              m_we = 1'b0;
  logic [REG_AW-1:0] m_ad = '0;
  logic [XLEN-1:0]   m_wd = '0;
  logic [XLEN-1:0]   m_rf [32];
  logic [XLEN-1:0]   d_rf [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_pending(input logic [REG_AW-1:0] ad);
    if (!rst || ad == '0) return 1'b0;
    if (m_we && m_ad == ad) return 1'b1;
    foreach (m_q[i]) if (m_q[i].valid && m_q[i].rd == ad) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] exp_fwd(input logic [REG_AW-1:0] ad);
    if (ad == '0) return '0;
`ifdef WB_ARBITER_FWD_EN
    if (m_we && m_ad == ad) return m_wd;
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].valid && m_q[i].rd == ad) return m_q[i].data;
`endif
    return '0;
  endfunction

  task automatic model_update();
    logic      fast;
    logic      acc;
    wb_entry_t e;
    if (!rst) begin
      m_we = 1'b0; m_ad = '0; m_wd = '0;
      m_q.delete();
      return;
    end
    fast = bus.alu_valid && (bus.alu_rd != '0);
    acc  = bus.lsu_valid && (m_q.size() < DEPTH) && (bus.lsu_rd != '0);
    if (fast)
      for (int i = 0; i < m_q.size(); i++)
        if (m_q[i].rd == bus.alu_rd) begin
          e = m_q[i]; e.valid = 1'b0; m_q[i] = e;
        end
    if (fast) begin
      m_we = 1'b1; m_ad = bus.alu_rd; m_wd = bus.alu_data;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = e.valid;
      if (e.valid) begin m_ad = e.rd; m_wd = e.data; end
    end else begin
      m_we = 1'b0;
    end
    if (m_we) m_rf[m_ad] = m_wd;
    if (acc) begin
      e.valid = !(fast && bus.alu_rd == bus.lsu_rd);
      e.rd    = bus.lsu_rd;
      e.data  = bus.lsu_data;
      m_q.push_back(e);
    end
  endtask

  task automatic drive(input logic av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] adat,
                       input logic lv, input logic [REG_AW-1:0] lrd, input logic [XLEN-1:0] ldat);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adat;
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ldat;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Called with clk low and inputs applied; checks, advances the model, one cycle.
  task automatic step();
    #1;
    check("lsu_ready", 64'(bus.lsu_ready), 64'(rst && (m_q.size() != DEPTH)));
    check("WE3", 64'(bus.WE3), 64'(m_we));
    if (m_we) begin
      check("AD3", 64'(bus.AD3), 64'(m_ad));
      check("WD3", 64'(bus.WD3), 64'(m_wd));
    end
    check("rs1_pending", 64'(bus.rs1_pending), 64'(exp_pending(bus.AD1)));
    check("rs2_pending", 64'(bus.rs2_pending), 64'(exp_pending(bus.AD2)));
    check("rs1_fwd", 64'(bus.rs1_fwd_data), 64'(exp_fwd(bus.AD1)));
    check("rs2_fwd", 64'(bus.rs2_fwd_data), 64'(exp_fwd(bus.AD2)));
    if (bus.WE3 === 1'b1) d_rf[bus.AD3] = bus.WD3;
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; d_rf[r] = '0; end
    idle();
    bus.AD1 = '0;
    bus.AD2 = '0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_WE3", 64'(bus.WE3), 64'd0);
    check("rst_AD3", 64'(bus.AD3), 64'd0);
    check("rst_WD3", 64'(bus.WD3), 64'd0);
    check("rst_ready", 64'(bus.lsu_ready), 64'd0);
    check("rst_pend1", 64'(bus.rs1_pending), 64'd0);
    rst = 1'b1;
    step();

    // Fast write lands one cycle later
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    step();
    idle();
    check("fast_WE3", 64'(bus.WE3), 64'd1);
    check("fast_AD3", 64'(bus.AD3), 64'd5);
    check("fast_WD3", 64'(bus.WD3), 64'hDEADBEEF);
    step();

    // Slow port: accept N, pop N+1, write N+2
    bus.AD1 = 5'd7;
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h11);
    step();
    idle();
    #1;
    check("slow_n1_WE3", 64'(bus.WE3), 64'd0);
    check("slow_n1_pend", 64'(bus.rs1_pending), 64'd1);
    step();
    check("slow_n2_WE3", 64'(bus.WE3), 64'd1);
    check("slow_n2_AD3", 64'(bus.AD3), 64'd7);
    check("slow_n2_WD3", 64'(bus.WD3), 64'h11);
    check("slow_n2_pend", 64'(bus.rs1_pending), 64'd1);
    step();

    // Backpressure: fill while the fast port hogs the slot, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b1, 5'(10 + i), 32'(32'h100 + i));
      step();
    end
    idle();
    #1;
    check("bp_ready_full", 64'(bus.lsu_ready), 64'd0);
    step();
    check("bp_ready_back", 64'(bus.lsu_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("bp_order_AD3", 64'(bus.AD3), 64'(10 + i));
      check("bp_order_WD3", 64'(bus.WD3), 64'(32'h100 + i));
      step();
    end

    // Squash of a buffered entry, then of a same-cycle enqueue
    drive(1'b0, '0, '0, 1'b1, 5'd3, 32'hA);
    step();
    drive(1'b1, 5'd3, 32'hB, 1'b0, '0, '0);
    step();
    idle();
    check("sq_fast_AD3", 64'(bus.AD3), 64'd3);
    check("sq_fast_WD3", 64'(bus.WD3), 64'hB);
    step();
    check("sq_drain_WE3", 64'(bus.WE3), 64'd0);
    drive(1'b1, 5'd4, 32'hC, 1'b1, 5'd4, 32'hD);
    step();
    idle();
    step();
    check("sq_same_WE3", 64'(bus.WE3), 64'd0);
    step();
    check("sq_x3", 64'(d_rf[3]), 64'hB);
    check("sq_x4", 64'(d_rf[4]), 64'hC);

    // x0 on either port: no write, no enqueue; alu x0 leaves the slot to the buffer
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
    step();
    bus.AD1 = '0;
    drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    step();
    idle();
    #1;
    check("x0_drain_AD3", 64'(bus.AD3), 64'd9);
    check("x0_pend_ad0", 64'(bus.rs1_pending), 64'd0);
    step();
    check("x0_no_enq_WE3", 64'(bus.WE3), 64'd0);
    step();

    // Reset with entries in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b1, 5'(20 + i), 32'(32'h200 + i));
      step();
    end
    idle();
    bus.AD1 = 5'd20;
    rst = 1'b0;
    #1;
    check("rstm_ready", 64'(bus.lsu_ready), 64'd0);
    check("rstm_pend", 64'(bus.rs1_pending), 64'd0);
    step();
    check("rstm_WE3", 64'(bus.WE3), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("rstm_stale20", 64'(d_rf[20]), 64'd0);
    check("rstm_stale22", 64'(d_rf[22]), 64'd0);

    // Random traffic on a small rd range for plenty of collisions
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      bus.AD1 = 5'($urandom_range(0, 7));
      bus.AD2 = 5'($urandom_range(0, 7));
      step();
    end
    rst = 1'b1;
    idle();
    for (int i = 0; i < DEPTH + 2; i++) step();
    for (int r = 0; r < 32; r++)
      check($sformatf("rf_x%0d", r), 64'(d_rf[r]), 64'(m_rf[r]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 4, giving the number of slow-port buffer entries (power of 2, at least 2).
REQ-002 The block SHALL provide parameter XLEN, default 32, giving the data width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 alu_valid  in  1  fast-port write request; no backpressure.
REQ-007 alu_rd  in  5  fast-port destination register.
REQ-008 alu_data  in  XLEN  fast-port write data.
REQ-009 lsu_valid  in  1  slow-port (load/mul-div) write request.
REQ-010 lsu_ready  out  1  slow-port accept; equals rst && (count != DEPTH).
REQ-011 lsu_rd  in  5  slow-port destination register.
REQ-012 lsu_data  in  XLEN  slow-port write data.
REQ-013 WE3  out  1  register-file write enable, registered.
REQ-014 AD3  out  5  register-file write address, registered.
REQ-015 WD3  out  XLEN  register-file write data, registered.
REQ-016 AD1  in  5  decode-stage read address 1.
REQ-017 AD2  in  5  decode-stage read address 2.
REQ-018 rs1_pending  out  1  AD1 has an outstanding write.
REQ-019 rs2_pending  out  1  AD2 has an outstanding write.
REQ-020 rs1_fwd_data  out  XLEN  forward data for AD1.
REQ-021 rs2_fwd_data  out  XLEN  forward data for AD2.

Function
REQ-022 A fast-port request in cycle N with alu_rd != 0 SHALL produce WE3=1, AD3=alu_rd and WD3=alu_data in cycle N+1.
REQ-023 A fast-port request with alu_rd == 0 SHALL produce WE3=0 in N+1, and the slot SHALL be available to drain the buffer.
REQ-024 A slow-port handshake (lsu_valid && lsu_ready) with lsu_rd != 0 SHALL enqueue {valid=1, rd, data}; with lsu_rd == 0 it SHALL be accepted and discarded.
REQ-025 When the fast port is not writing and the buffer is non-empty, the head SHALL pop; a valid head SHALL drive WE3/AD3/WD3 in the next cycle, and an invalid head SHALL produce WE3=0.
REQ-026 Minimum slow-port latency SHALL be 2 cycles: accept at N, pop at N+1, WE3 at N+2; there is no bypass.
REQ-027 The fast port SHALL always win arbitration; buffer entries SHALL drain in FIFO order.
REQ-028 Fast-port writes are by definition younger: a fast write with alu_rd != 0 SHALL clear the valid bit of every buffered entry with the same rd, including an entry enqueued in the same cycle.
REQ-029 lsu_ready SHALL depend only on the registered count, with no pop-through when full; a simultaneous push and pop SHALL leave count unchanged.
REQ-030 Pointers SHALL wrap modulo DEPTH, and count SHALL range 0..DEPTH.
REQ-031 rsX_pending SHALL be 1 when ADX != 0 and either a valid buffered entry has rd == ADX or (WE3 && AD3 == ADX); otherwise 0.

Reset
REQ-032 While rst == 0 at a rising edge: WE3=0, AD3=0, WD3=0, buffer emptied (all valid bits 0, pointers 0, count 0).
REQ-033 While rst == 0, lsu_ready, rs1_pending and rs2_pending SHALL be 0, and all buffered entries in flight SHALL be discarded.

Configuration
REQ-034 Macro WB_ARBITER_FWD_EN SHALL control forwarding.
REQ-035 With WB_ARBITER_FWD_EN defined, rsX_fwd_data SHALL be the data of the in-flight WE3 stage if it matches ADX, else the youngest valid matching buffer entry, else 0.
REQ-036 Without WB_ARBITER_FWD_EN, rsX_fwd_data SHALL be tied to 0 and no compare-data mux logic SHALL be synthesised.

Structure
REQ-037 Package wb_pkg SHALL hold XLEN_DEF=32, REG_AW=5, and typedef wb_entry_t {logic valid; logic [4:0] rd; logic [XLEN-1:0] data}.
REQ-038 Sub-module wb_fifo SHALL implement the circular buffer with the squash compare and the per-entry rd match vectors.
REQ-039 The arbitration and the output register SHALL stay in wb_arbiter.

Verification
REQ-040 Fast write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at N -> WE3=1, AD3=5, WD3=0xDEADBEEF at N+1.
REQ-041 Slow-port latency: lsu rd=7, data=0x11 at N with the fast port idle -> WE3=1, AD3=7 at N+2; rs1_pending=1 with AD1=7 during N+1 and N+2.
REQ-042 Backpressure: fast port busy, 4 slow accepts -> lsu_ready=0 in the next cycle; fast port idle -> entries written in order over 4 cycles; lsu_ready returns to 1 one cycle after the first pop.
REQ-043 Squash: buffered rd=3 data=0xA, then fast rd=3 data=0xB -> only 0xB is written, the buffered slot drains with WE3=0, and the final x3 is 0xB.
REQ-044 x0 handling: alu_rd=0 or lsu_rd=0 -> no WE3 pulse and no enqueue; rs1_pending=0 for AD1=0.
REQ-045 Reset mid-operation: rst=0 with 3 entries buffered -> WE3=0 and lsu_ready=0; after rst=1, count=0 and no stale write appears.
